// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit driving a word-only DMEM port: sub-word load extraction and SB/SH read-modify-write.
// Optional LSU_RANGE_CHECK_EN: addresses at or beyond DMEM_WORDS*4 complete with resp_err and no memory access.
module lsu_dmem_ctrl #(
    parameter int unsigned DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_RANGE_CHECK_EN
    localparam logic LP_RANGE_EN = 1'b1;
`else
    localparam logic LP_RANGE_EN = 1'b0;
`endif
    localparam logic [32:0] LP_LIMIT = 33'(DMEM_WORDS) * 33'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_illegal;
    logic        w_out_of_range;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_word;
    logic        w_access;

    // Legality is judged on the live request inputs at the accept edge.
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: w_illegal = req_we && req_funct3[2];
            F3_H, F3_HU: w_illegal = (req_we && req_funct3[2]) || req_addr[0];
            F3_W:        w_illegal = (req_addr[1:0] != 2'b00);
            default:     w_illegal = 1'b1;
        endcase
    end

    assign w_out_of_range = LP_RANGE_EN && ({1'b0, req_addr} >= LP_LIMIT);
    assign w_err          = w_illegal || w_out_of_range;

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        w_load_data = mem_rdata;
        case (r_funct3)
            F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   w_load_data = {24'd0, w_byte};
            F3_HU:   w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // funct3[0] separates SH from SB; both reach RMW only after passing legality.
    always_comb begin
        w_merge_word = r_word;
        if (r_funct3[0]) begin
            if (r_addr[1]) begin
                w_merge_word[31:16] = r_wdata[15:0];
            end else begin
                w_merge_word[15:0] = r_wdata[15:0];
            end
        end else begin
            case (r_addr[1:0])
                2'd0: w_merge_word[7:0]   = r_wdata[7:0];
                2'd1: w_merge_word[15:8]  = r_wdata[7:0];
                2'd2: w_merge_word[23:16] = r_wdata[7:0];
                2'd3: w_merge_word[31:24] = r_wdata[7:0];
                default: w_merge_word = r_word;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else if (!req_we) begin
                            r_state <= S_LOAD;
                        end else if (req_funct3 == F3_W) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_load_data;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_WRITE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RMW_RD: begin
                    r_word  <= mem_rdata;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory strobes decode straight from state so an async reset drops them at once.
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_read   = (r_state == S_LOAD)  || (r_state == S_RMW_RD);
    assign mem_write  = (r_state == S_WRITE) || (r_state == S_RMW_WR);
    assign w_access   = mem_read || mem_write;
    assign mem_addr   = w_access ? {r_addr[31:2], 2'b00} : '0;

    always_comb begin
        mem_wdata = '0;
        if (r_state == S_WRITE) begin
            mem_wdata = r_wdata;
        end else if (r_state == S_RMW_WR) begin
            mem_wdata = w_merge_word;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl with a word-only DMEM model and a response scoreboard.
// Range expectations follow LSU_RANGE_CHECK_EN as defined for the build.
module tb_lsu_dmem_ctrl;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [0:255];

    int   errors = 0;
    int   checks = 0;
    exp_t scb[$];

    always #5 clk = ~clk;

    lsu_dmem_ctrl #(.DMEM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
    end

    // Waits for IDLE, pushes the expected response, and presents the request for one accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        int   n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        e.err   = e_err;
        e.rdata = e_rd;
        e.lat   = e_err ? 1 : ((we && f3 != F_W) ? 3 : 2);
        e.nrd   = (!e_err && (!we || f3 != F_W)) ? 1 : 0;
        e.nwr   = (!e_err && we) ? 1 : 0;
        scb.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
    endtask

    // Observes cycles after the accept edge until resp_valid; checks memory-port invariants per cycle.
    task automatic wait_resp(output logic o_err, output logic [31:0] o_rd, output int o_lat,
                             output int o_nrd, output int o_nwr);
        bit got;
        got   = 1'b0;
        o_lat = 1;
        o_nrd = 0;
        o_nwr = 0;
        o_err = 1'bx;
        o_rd  = 'x;
        while (!got && o_lat <= 8) begin
            @(negedge clk);
            checks++;
            if ((mem_read && mem_write) || (mem_addr[1:0] !== 2'b00) ||
                (!mem_read && !mem_write && (mem_addr !== 32'd0 || mem_wdata !== 32'd0))) begin
                errors++;
                $display("FAIL mem_port: read=%b write=%b addr=%h wdata=%h required exclusive strobes, aligned addr, zero when idle",
                         mem_read, mem_write, mem_addr, mem_wdata);
            end
            if (mem_read)  o_nrd++;
            if (mem_write) o_nwr++;
            if (resp_valid) begin
                got   = 1'b1;
                o_err = resp_err;
                o_rd  = resp_rdata;
            end else begin
                o_lat++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            o_lat = -1;
            $display("FAIL resp_timeout: no resp_valid within 8 cycles, required a response");
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b err=%b rdata=%h required 1 0 0 00000000",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem: read=%b write=%b addr=%h wdata=%h required all zero",
                     mem_read, mem_write, mem_addr, mem_wdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_store_load();
        req_t t [2];
        exp_t e;
        logic err; logic [31:0] rd; int lat, nrd, nwr;
        t = '{'{1'b1, F_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0},
              '{1'b0, F_W, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF}};
        for (int i = 0; i < 2; i++) begin
            issue(t[i].we, t[i].f3, t[i].a, t[i].wd, t[i].err, t[i].rd);
            wait_resp(err, rd, lat, nrd, nwr);
            e = scb.pop_front();
            checks++;
            if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
                errors++;
                $display("FAIL store_load[%0d]: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                         i, err, rd, lat, e.err, e.rdata, e.lat);
            end
            checks++;
            if (nrd !== e.nrd || nwr !== e.nwr) begin
                errors++;
                $display("FAIL store_load_access[%0d]: reads=%0d writes=%0d required %0d %0d", i, nrd, nwr, e.nrd, e.nwr);
            end
        end
    endtask

    task automatic test_subword_load();
        req_t t [14];
        exp_t e;
        logic err; logic [31:0] rd; int lat, nrd, nwr;
        t = '{'{1'b1, F_W,  32'h8, 32'h11223344, 1'b0, 32'h0},
              '{1'b0, F_B,  32'hB, 32'h0, 1'b0, 32'h00000011},
              '{1'b0, F_B,  32'h8, 32'h0, 1'b0, 32'h00000044},
              '{1'b0, F_H,  32'hA, 32'h0, 1'b0, 32'h00001122},
              '{1'b0, F_HU, 32'h8, 32'h0, 1'b0, 32'h00003344},
              '{1'b1, F_W,  32'h8, 32'h000000F0, 1'b0, 32'h0},
              '{1'b0, F_B,  32'h8, 32'h0, 1'b0, 32'hFFFFFFF0},
              '{1'b0, F_BU, 32'h8, 32'h0, 1'b0, 32'h000000F0},
              '{1'b1, F_W,  32'h8, 32'hFFFF8001, 1'b0, 32'h0},
              '{1'b0, F_H,  32'hA, 32'h0, 1'b0, 32'hFFFFFFFF},
              '{1'b0, F_H,  32'h8, 32'h0, 1'b0, 32'hFFFF8001},
              '{1'b0, F_HU, 32'h8, 32'h0, 1'b0, 32'h00008001},
              '{1'b0, F_BU, 32'h9, 32'h0, 1'b0, 32'h00000080},
              '{1'b0, F_B,  32'h9, 32'h0, 1'b0, 32'hFFFFFF80}};
        for (int i = 0; i < 14; i++) begin
            issue(t[i].we, t[i].f3, t[i].a, t[i].wd, t[i].err, t[i].rd);
            wait_resp(err, rd, lat, nrd, nwr);
            e = scb.pop_front();
            checks++;
            if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
                errors++;
                $display("FAIL subword_load[%0d]: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                         i, err, rd, lat, e.err, e.rdata, e.lat);
            end
            checks++;
            if (nrd !== e.nrd || nwr !== e.nwr) begin
                errors++;
                $display("FAIL subword_access[%0d]: reads=%0d writes=%0d required %0d %0d", i, nrd, nwr, e.nrd, e.nwr);
            end
        end
    endtask

    task automatic test_rmw();
        req_t t [11];
        exp_t e;
        logic err; logic [31:0] rd; int lat, nrd, nwr;
        t = '{'{1'b1, F_W,  32'h20, 32'hAABBCCDD, 1'b0, 32'h0},
              '{1'b1, F_B,  32'h21, 32'h00000055, 1'b0, 32'h0},
              '{1'b0, F_W,  32'h20, 32'h0, 1'b0, 32'hAABB55DD},
              '{1'b1, F_H,  32'h22, 32'hFFFF1234, 1'b0, 32'h0},
              '{1'b0, F_W,  32'h20, 32'h0, 1'b0, 32'h123455DD},
              '{1'b1, F_B,  32'h20, 32'hAAAAAA99, 1'b0, 32'h0},
              '{1'b1, F_B,  32'h23, 32'h00000000, 1'b0, 32'h0},
              '{1'b0, F_W,  32'h20, 32'h0, 1'b0, 32'h00345599},
              '{1'b1, F_H,  32'h20, 32'h0000BEEF, 1'b0, 32'h0},
              '{1'b0, F_W,  32'h20, 32'h0, 1'b0, 32'h0034BEEF},
              '{1'b0, F_HU, 32'h22, 32'h0, 1'b0, 32'h00000034}};
        for (int i = 0; i < 11; i++) begin
            issue(t[i].we, t[i].f3, t[i].a, t[i].wd, t[i].err, t[i].rd);
            wait_resp(err, rd, lat, nrd, nwr);
            e = scb.pop_front();
            checks++;
            if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
                errors++;
                $display("FAIL rmw[%0d]: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                         i, err, rd, lat, e.err, e.rdata, e.lat);
            end
            checks++;
            if (nrd !== e.nrd || nwr !== e.nwr) begin
                errors++;
                $display("FAIL rmw_access[%0d]: reads=%0d writes=%0d required %0d %0d", i, nrd, nwr, e.nrd, e.nwr);
            end
        end
    endtask

    task automatic test_errors();
        req_t t [12];
        exp_t e;
        logic err; logic [31:0] rd; int lat, nrd, nwr;
        t = '{'{1'b0, F_W,    32'h6,  32'h0, 1'b1, 32'h0},
              '{1'b1, F_H,    32'h3,  32'h0, 1'b1, 32'h0},
              '{1'b0, 3'b011, 32'h0,  32'h0, 1'b1, 32'h0},
              '{1'b0, 3'b110, 32'h0,  32'h0, 1'b1, 32'h0},
              '{1'b0, 3'b111, 32'h0,  32'h0, 1'b1, 32'h0},
              '{1'b1, F_BU,   32'h10, 32'h0, 1'b1, 32'h0},
              '{1'b1, F_HU,   32'h10, 32'h0, 1'b1, 32'h0},
              '{1'b0, F_H,    32'h5,  32'h0, 1'b1, 32'h0},
              '{1'b0, F_HU,   32'h7,  32'h0, 1'b1, 32'h0},
              '{1'b1, F_W,    32'h12, 32'h0, 1'b1, 32'h0},
              '{1'b1, F_H,    32'h1,  32'h0, 1'b1, 32'h0},
              '{1'b0, F_W,    32'h10, 32'h0, 1'b0, 32'hDEADBEEF}};
        for (int i = 0; i < 12; i++) begin
            issue(t[i].we, t[i].f3, t[i].a, t[i].wd, t[i].err, t[i].rd);
            wait_resp(err, rd, lat, nrd, nwr);
            e = scb.pop_front();
            checks++;
            if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
                errors++;
                $display("FAIL errors[%0d]: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                         i, err, rd, lat, e.err, e.rdata, e.lat);
            end
            checks++;
            if (nrd !== e.nrd || nwr !== e.nwr) begin
                errors++;
                $display("FAIL errors_access[%0d]: reads=%0d writes=%0d required %0d %0d", i, nrd, nwr, e.nrd, e.nwr);
            end
        end
    endtask

    task automatic test_range();
        req_t t [5];
        exp_t e;
        logic err; logic [31:0] rd; int lat, nrd, nwr;
        t = '{'{1'b1, F_W,  32'h0,   32'h0BADF00D, 1'b0, 32'h0},
              '{1'b1, F_W,  32'h3FC, 32'h600DCAFE, 1'b0, 32'h0},
              '{1'b0, F_W,  32'h3FC, 32'h0, 1'b0, 32'h600DCAFE},
              '{1'b0, F_W,  32'h400, 32'h0, 1'b0, 32'h0BADF00D},
              '{1'b0, F_BU, 32'h7FF, 32'h0, 1'b0, 32'h00000060}};
`ifdef LSU_RANGE_CHECK_EN
        t[3].err = 1'b1; t[3].rd = 32'h0;
        t[4].err = 1'b1; t[4].rd = 32'h0;
`endif
        for (int i = 0; i < 5; i++) begin
            issue(t[i].we, t[i].f3, t[i].a, t[i].wd, t[i].err, t[i].rd);
            wait_resp(err, rd, lat, nrd, nwr);
            e = scb.pop_front();
            checks++;
            if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
                errors++;
                $display("FAIL range[%0d]: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                         i, err, rd, lat, e.err, e.rdata, e.lat);
            end
            checks++;
            if (nrd !== e.nrd || nwr !== e.nwr) begin
                errors++;
                $display("FAIL range_access[%0d]: reads=%0d writes=%0d required %0d %0d", i, nrd, nwr, e.nrd, e.nwr);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic err; logic [31:0] rd; int lat, nrd, nwr;
        int   acc_cycle;
        int   resp_cycles [2];
        int   nresp;
        issue(1'b1, F_W, 32'h40, 32'h89ABCDEF, 1'b0, 32'h0);
        wait_resp(err, rd, lat, nrd, nwr);
        e = scb.pop_front();
        checks++;
        if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
            errors++;
            $display("FAIL b2b_setup: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                     err, rd, lat, e.err, e.rdata, e.lat);
        end
        issue(1'b0, F_W, 32'h40, 32'h0, 1'b0, 32'h89ABCDEF);
        // Second request held valid from the cycle after the first accept.
        e.err = 1'b0; e.rdata = 32'hFFFFFF89; e.lat = 2; e.nrd = 1; e.nwr = 0;
        scb.push_back(e);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_B; req_addr = 32'h43;
        acc_cycle = -1;
        nresp = 0;
        resp_cycles[0] = -1;
        resp_cycles[1] = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid && nresp < 2) begin
                resp_cycles[nresp] = c;
                nresp++;
                e = scb.pop_front();
                checks++;
                if (resp_err !== e.err || resp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: err=%b rdata=%h required err=%b rdata=%h",
                             nresp - 1, resp_err, resp_rdata, e.err, e.rdata);
                end
            end
            if (req_valid && req_ready === 1'b1) begin
                acc_cycle = c;
                @(posedge clk);
                #1;
                req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (acc_cycle !== 3 || resp_cycles[0] !== 2 || resp_cycles[1] !== 5) begin
            errors++;
            $display("FAIL b2b_timing: accept=%0d resp1=%0d resp2=%0d required 3 2 5",
                     acc_cycle, resp_cycles[0], resp_cycles[1]);
        end
        while (scb.size() > 0) void'(scb.pop_front());
    endtask

    task automatic test_random();
        logic [7:0]  shb [64];
        exp_t        e;
        logic        err; logic [31:0] rd; int lat, nrd, nwr;
        logic [31:0] d, exp_rd;
        logic [2:0]  f3;
        logic        we;
        int          op, off;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            issue(1'b1, F_W, 32'h100 + 32'(w * 4), d, 1'b0, 32'h0);
            wait_resp(err, rd, lat, nrd, nwr);
            void'(scb.pop_front());
            for (int b = 0; b < 4; b++) shb[w * 4 + b] = d[b * 8 +: 8];
        end
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 7);
            off = $urandom_range(0, 63);
            d = $urandom;
            we = (op >= 5);
            case (op)
                0: f3 = F_B;  1: f3 = F_BU; 2: f3 = F_H;  3: f3 = F_HU;
                4: f3 = F_W;  5: f3 = F_B;  6: f3 = F_H;  default: f3 = F_W;
            endcase
            if (f3 == F_H || f3 == F_HU) off = off & ~1;
            if (f3 == F_W) off = off & ~3;
            exp_rd = 32'h0;
            if (!we) begin
                case (f3)
                    F_B:  exp_rd = {{24{shb[off][7]}}, shb[off]};
                    F_BU: exp_rd = {24'h0, shb[off]};
                    F_H:  exp_rd = {{16{shb[off + 1][7]}}, shb[off + 1], shb[off]};
                    F_HU: exp_rd = {16'h0, shb[off + 1], shb[off]};
                    default: exp_rd = {shb[off + 3], shb[off + 2], shb[off + 1], shb[off]};
                endcase
            end
            issue(we, f3, 32'h100 + 32'(off), d, 1'b0, exp_rd);
            wait_resp(err, rd, lat, nrd, nwr);
            e = scb.pop_front();
            checks++;
            if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
                errors++;
                $display("FAIL random[%0d] we=%b f3=%b off=%0d: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                         n, we, f3, off, err, rd, lat, e.err, e.rdata, e.lat);
            end
            if (we) begin
                shb[off] = d[7:0];
                if (f3 != F_B) shb[off + 1] = d[15:8];
                if (f3 == F_W) begin
                    shb[off + 2] = d[23:16];
                    shb[off + 3] = d[31:24];
                end
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        exp_t e;
        logic err; logic [31:0] rd; int lat, nrd, nwr;
        bit   saw_resp;
        issue(1'b1, F_W, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0);
        wait_resp(err, rd, lat, nrd, nwr);
        void'(scb.pop_front());
        while (req_ready !== 1'b1) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_B; req_addr = 32'h31; req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: mem_write=%b required 1 in write phase of SB", mem_write);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: mem_write=%b resp_valid=%b ready=%b required 0 0 1",
                     mem_write, resp_valid, req_ready);
        end
        saw_resp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        checks++;
        if (saw_resp) begin
            errors++;
            $display("FAIL rst_mid_resp: resp_valid seen=1 required 0 after aborted SB");
        end
        checks++;
        if (dmem[12] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rst_mid_word: dmem[0x30]=%h required cafef00d", dmem[12]);
        end
        issue(1'b0, F_W, 32'h30, 32'h0, 1'b0, 32'hCAFEF00D);
        wait_resp(err, rd, lat, nrd, nwr);
        e = scb.pop_front();
        checks++;
        if (err !== e.err || rd !== e.rdata || lat !== e.lat) begin
            errors++;
            $display("FAIL rst_mid_reload: err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=%0d",
                     err, rd, lat, e.err, e.rdata, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword_load();
        test_rmw();
        test_errors();
        test_range();
        test_back_to_back();
        test_random();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
